// File: rtl/adder_share_pkg.sv
// Shared constants and result record for the shared-adder arbiter.
package adder_share_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TAGW = 2;
  localparam int unsigned SUMW = 17;
  localparam int unsigned AW   = 16;
  localparam int unsigned BW   = 8;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [SUMW-1:0] data;
  } result_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester and result-consumer signals of the shared-adder arbiter.
interface adder_share_arbiter_if;
  import adder_share_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] in1_bus;
  logic [NREQ*BW-1:0] in2_bus;
  logic [NREQ-1:0]    grant;
  logic               res_valid;
  logic               res_ready;
  logic [SUMW-1:0]    res_data;
  logic [TAGW-1:0]    res_tag;
  logic               busy;

  modport master (
    output req, in1_bus, in2_bus, res_ready,
    input  grant, res_valid, res_data, res_tag, busy
  );

  modport slave (
    input  req, in1_bus, in2_bus, res_ready,
    output grant, res_valid, res_data, res_tag, busy
  );

endinterface

// File: rtl/adder_result_fifo.sv
// Two-entry show-ahead FIFO of tagged adder results.
module adder_result_fifo
  import adder_share_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  result_t    push_entry,
  input  logic       pop,
  output result_t    head,
  output logic       valid,
  output logic [1:0] count
);

  result_t    mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       pop_ok;

  assign pop_ok = pop & (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // When full, wr_ptr equals rd_ptr, so a push+pop overwrites the slot being retired.
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/bigadder.sv
// 16-bit + 8-bit unsigned adder with one output register stage.
module bigadder
  import adder_share_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   in1,
  input  logic [BW-1:0]   in2,
  output logic [SUMW-1:0] out
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= SUMW'(in1) + SUMW'(in2);
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one registered bigadder among four requesters,
// with credit-limited issue into a 2-entry tagged result FIFO.
module adder_share_arbiter
  import adder_share_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  adder_share_arbiter_if.slave bus
);

  logic [TAGW-1:0] rr_ptr_q;
  logic [TAGW-1:0] sel_q;
  logic [TAGW-1:0] sel;
  logic [TAGW-1:0] p1_tag_q;
  logic            p1_valid_q;
  logic            rst_done_q;
  logic [TAGW-1:0] grant_idx;
  logic [TAGW-1:0] idx;
  logic            grant_any;
  logic            issue;
  logic            issue_ok;
  logic [2:0]      occupancy;
  logic            pop;
  logic            fifo_valid;
  logic [1:0]      fifo_count;
  result_t         fifo_head;
  result_t         push_entry;
  logic [AW-1:0]   adder_a;
  logic [BW-1:0]   adder_b;
  logic [SUMW-1:0] adder_out;

  assign pop       = fifo_valid & bus.res_ready;
  // Slots committed after this cycle: in the adder plus buffered, less what leaves now.
  assign occupancy = {2'b00, p1_valid_q} + {1'b0, fifo_count} - {2'b00, pop};
  assign issue_ok  = (occupancy < 3'd2);

  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = rr_ptr_q + TAGW'(off);
      if (!grant_any && bus.req[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    // rst_done_q keeps grant low through the first edge after reset release.
    issue     = grant_any & issue_ok & rst_done_q;
    bus.grant = issue ? (NREQ'(1) << grant_idx) : '0;
  end

  assign sel     = issue ? grant_idx : sel_q;
  assign adder_a = bus.in1_bus[{sel, 4'b0000} +: AW];
  assign adder_b = bus.in2_bus[{sel, 3'b000} +: BW];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      p1_tag_q   <= '0;
      p1_valid_q <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      p1_valid_q <= issue;
      sel_q      <= sel;
      if (issue) begin
        rr_ptr_q <= grant_idx + TAGW'(1);
        p1_tag_q <= grant_idx;
      end
    end
  end

  bigadder u_adder (
    .clock (clock),
    .reset (reset),
    .in1   (adder_a),
    .in2   (adder_b),
    .out   (adder_out)
  );

  assign push_entry = '{tag: p1_tag_q, data: adder_out};

  adder_result_fifo u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (p1_valid_q),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .valid      (fifo_valid),
    .count      (fifo_count)
  );

  assign bus.res_valid = fifo_valid;
  assign bus.res_data  = fifo_head.data;
  assign bus.res_tag   = fifo_head.tag;
  assign bus.busy      = p1_valid_q | (fifo_count != 2'd0);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scenario bench for adder_share_arbiter; results are scored against a queue of expected sums.
module tb_adder_share_arbiter;
  import adder_share_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [AW-1:0] a [NREQ];
  logic [BW-1:0] b [NREQ];
  result_t       exp_q [$];

  adder_share_arbiter_if bus ();

  adder_share_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.in1_bus = {a[3], a[2], a[1], a[0]};
  assign bus.in2_bus = {b[3], b[2], b[1], b[0]};

  function automatic result_t expect_of(input int i);
    result_t r;
    r.tag  = TAGW'(i);
    r.data = SUMW'(a[i]) + SUMW'(b[i]);
    return r;
  endfunction

  // Result scoreboard and full-FIFO push guard.
  always @(negedge clock) begin
    result_t e;
    if (!reset) begin
      if (bus.res_valid && bus.res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got tag=%0d data=%h, none expected",
                   bus.res_tag, bus.res_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.res_tag !== e.tag || bus.res_data !== e.data) begin
            errors++;
            $display("FAIL result got tag=%0d data=%h expected tag=%0d data=%h",
                     bus.res_tag, bus.res_data, e.tag, e.data);
          end
        end
      end
      checks++;
      if ((dut.p1_valid_q && dut.fifo_count == 2'd2 && !(bus.res_valid && bus.res_ready))
          !== 1'b0) begin
        errors++;
        $display("FAIL push_into_full got count=%0d with push and no pop, expected no push",
                 dut.fifo_count);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.req       = '0;
    bus.res_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.busy) && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d results outstanding, expected 0", name, exp_q.size());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got %b expected 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req       = 4'b1111;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    repeat (2) @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant got %b expected 0000", bus.grant);
    end
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_res_valid got %b expected 0", bus.res_valid);
    end
    checks++;
    if (bus.res_data !== 17'h0 || bus.res_tag !== 2'd0) begin
      errors++;
      $display("FAIL reset_res got data=%h tag=%0d expected 0/0", bus.res_data, bus.res_tag);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b expected 0", bus.busy);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0000) begin
      errors++; $display("FAIL grant_first_edge got %b expected 0000", bus.grant);
    end
    next_cycle();
    bus.req = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 16'(16'h1000 * (i + 1) + i);
      b[i] = 8'(8'h11 * (i + 1));
    end
    bus.res_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      bus.req = (k < 5) ? 4'b1111 : 4'b0000;
      @(negedge clock);
      eg = (k < 5) ? 4'(1 << (k % 4)) : 4'b0000;
      checks++;
      if (bus.grant !== eg) begin
        errors++; $display("FAIL rr_grant[%0d] got %b expected %b", k, bus.grant, eg);
      end
      if (k < 5) exp_q.push_back(expect_of(k % 4));
      if (k >= 2) begin
        checks++;
        if (bus.res_valid !== 1'b1) begin
          errors++; $display("FAIL rr_stream[%0d] got res_valid=%b expected 1", k, bus.res_valid);
        end
      end
    end
    drain("rr");
  endtask

  task automatic test_single();
    next_cycle();
    a[2]    = 16'hFFFF;
    b[2]    = 8'hFF;
    bus.req = 4'b0100;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++; $display("FAIL single_grant got %b expected 0100", bus.grant);
    end
    exp_q.push_back(expect_of(2));
    next_cycle();
    bus.req = '0;
    @(negedge clock);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency_t1 got res_valid=%b expected 0", bus.res_valid);
    end
    @(negedge clock);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 17'h100FE || bus.res_tag !== 2'd2) begin
      errors++;
      $display("FAIL single_result got v=%b data=%h tag=%0d expected 1/100fe/2",
               bus.res_valid, bus.res_data, bus.res_tag);
    end
    drain("single");
  endtask

  task automatic test_rotation();
    next_cycle();
    a[3]    = 16'h0F0F;
    b[3]    = 8'h0F;
    bus.req = 4'b1000;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b1000) begin
      errors++; $display("FAIL rot_grant3 got %b expected 1000", bus.grant);
    end
    exp_q.push_back(expect_of(3));
    next_cycle();
    a[0]    = 16'h0101;
    b[0]    = 8'h01;
    bus.req = 4'b1001;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++; $display("FAIL rot_grant0 got %b expected 0001", bus.grant);
    end
    exp_q.push_back(expect_of(0));
    next_cycle();
    drain("rot");
  endtask

  task automatic test_backpressure();
    int ei [9] = '{1, 2, -1, -1, -1, 3, 0, 1, 2};
    logic [3:0] eg;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 16'(16'hA000 + 16'h0111 * i);
      b[i] = 8'(8'h20 + i);
    end
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      bus.req       = 4'b1111;
      bus.res_ready = (k >= 5);
      @(negedge clock);
      eg = (ei[k] < 0) ? 4'b0000 : 4'(1 << ei[k]);
      checks++;
      if (bus.grant !== eg) begin
        errors++; $display("FAIL bp_grant[%0d] got %b expected %b", k, bus.grant, eg);
      end
      if (ei[k] >= 0) exp_q.push_back(expect_of(ei[k]));
      if (k == 4) begin
        checks++;
        if (dut.fifo_count !== 2'd2) begin
          errors++; $display("FAIL bp_fifo_count got %0d expected 2", dut.fifo_count);
        end
      end
    end
    next_cycle();
    drain("bp");
  endtask

  task automatic test_operands();
    next_cycle();
    a[0]    = 16'h1234;
    b[0]    = 8'h00;
    bus.req = 4'b0001;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++; $display("FAIL ops_grant0 got %b expected 0001", bus.grant);
    end
    exp_q.push_back('{tag: 2'd0, data: 17'h01234});
    next_cycle();
    a[1]    = 16'h0000;
    b[1]    = 8'h80;
    bus.req = 4'b0010;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0010) begin
      errors++; $display("FAIL ops_grant1 got %b expected 0010", bus.grant);
    end
    exp_q.push_back('{tag: 2'd1, data: 17'h00080});
    next_cycle();
    drain("ops");
  endtask

  task automatic test_reset_midflight();
    a[1] = 16'hAAAA;
    b[1] = 8'h55;
    a[2] = 16'h5555;
    b[2] = 8'hAA;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      bus.req       = 4'b0110;
      bus.res_ready = 1'b0;
      @(negedge clock);
    end
    next_cycle();
    checks++;
    if (bus.busy !== 1'b1 || bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_loaded got busy=%b res_valid=%b expected 1/1", bus.busy, bus.res_valid);
    end
    reset         = 1'b1;
    bus.res_ready = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset got v=%b busy=%b grant=%b expected 0/0/0000",
               bus.res_valid, bus.busy, bus.grant);
    end
    next_cycle();
    bus.req = 4'b1111;
    a[0]    = 16'h7777;
    b[0]    = 8'h11;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0000) begin
      errors++; $display("FAIL mid_first_edge got %b expected 0000", bus.grant);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++; $display("FAIL mid_first_grant got %b expected 0001", bus.grant);
    end
    exp_q.push_back(expect_of(0));
    next_cycle();
    drain("mid");
  endtask

  initial begin
    bus.req       = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_single();
    test_rotation();
    test_backpressure();
    test_operands();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion by 200000 time units, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
